sram_d_arbiter: RTL and testbench

Two-master OBI arbiter sitting directly upstream of the SRAM wrapper's data port (`sram_d_*`). Multiplexes the core data port (master 0) and the boot loader/DMA port (master 1) onto the single data-side OBI interface. Records the ID of each granted transaction in a small in-order FIFO so that every `rvalid`/`rdata` is returned to the master that issued it. Flags responses that arrive with no transaction outstanding.

---
 rtl/sram_d_arb_pkg.sv | 13 +
 rtl/sram_d_arb_idfifo.sv | 56 +++++
 rtl/sram_d_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_d_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_d_arb_pkg.sv
// Shared types and OBI widths for the data-side SRAM arbiter.
package sram_d_arb_pkg;

  typedef enum logic {
    M_CORE   = 1'b0,
    M_LOADER = 1'b1
  } master_id_e;

  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;
  localparam int OBI_BE_W   = 4;

endpackage

// File: rtl/sram_d_arb_idfifo.sv
// In-order FIFO of master IDs for accepted-but-unanswered OBI transactions.
module sram_d_arb_idfifo
  import sram_d_arb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  master_id_e       push_id_i,
  input  logic             pop_i,
  output master_id_e       head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  master_id_e       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign head_o  = mem[rd_ptr];

  // Guarded locally so a misbehaving caller cannot corrupt the pointers.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= M_CORE;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_d_arbiter.sv
// Two-master OBI arbiter in front of the SRAM data port; routes responses back
// to the issuing master via an in-order ID FIFO and flags orphan responses.
module sram_d_arbiter
  import sram_d_arb_pkg::*;
#(
  parameter int OUTSTANDING_DEPTH = 2,
  parameter int FIXED_PRIORITY    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [OBI_ADDR_W-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [OBI_BE_W-1:0]   m0_be_i,
  input  logic [OBI_DATA_W-1:0] m0_wdata_i,
  output logic                  m0_rvalid_o,
  output logic [OBI_DATA_W-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [OBI_ADDR_W-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [OBI_BE_W-1:0]   m1_be_i,
  input  logic [OBI_DATA_W-1:0] m1_wdata_i,
  output logic                  m1_rvalid_o,
  output logic [OBI_DATA_W-1:0] m1_rdata_o,
  output logic                  s_req_o,
  input  logic                  s_gnt_i,
  output logic [OBI_ADDR_W-1:0] s_addr_o,
  output logic                  s_we_o,
  output logic [OBI_BE_W-1:0]   s_be_o,
  output logic [OBI_DATA_W-1:0] s_wdata_o,
  input  logic                  s_rvalid_i,
  input  logic [OBI_DATA_W-1:0] s_rdata_i,
  output logic                  resp_err_o
);

  localparam int CNT_W = $clog2(OUTSTANDING_DEPTH) + 1;

  // Handshake: a transfer is accepted in the cycle where s_req_o && s_gnt_i;
  // the chosen master sees gnt in that same cycle and must hold req/fields
  // until then. Responses carry no back-pressure: s_rvalid_i is consumed the
  // cycle it arrives and routed to the FIFO head.

  master_id_e       last_grant;
  master_id_e       sel;
  master_id_e       head_id;
  logic             sel_valid;
  logic             elig0;
  logic             elig1;
  logic             accept;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] unused_count;

  assign elig0 = m0_req_i && !fifo_full;
  assign elig1 = m1_req_i && !fifo_full;

  always_comb begin
    sel       = M_CORE;
    sel_valid = elig0 || elig1;
    if (elig0 && elig1) begin
      if (FIXED_PRIORITY != 0)         sel = M_CORE;
      else if (last_grant == M_CORE)   sel = M_LOADER;
      else                             sel = M_CORE;
    end else if (elig1) begin
      sel = M_LOADER;
    end
  end

  always_comb begin
    s_req_o   = 1'b0;
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (sel_valid) begin
      s_req_o = 1'b1;
      if (sel == M_CORE) begin
        s_addr_o  = m0_addr_i;
        s_we_o    = m0_we_i;
        s_be_o    = m0_be_i;
        s_wdata_o = m0_wdata_i;
      end else begin
        s_addr_o  = m1_addr_i;
        s_we_o    = m1_we_i;
        s_be_o    = m1_be_i;
        s_wdata_o = m1_wdata_i;
      end
    end
  end

  assign accept   = s_req_o && s_gnt_i;
  assign m0_gnt_o = accept && (sel == M_CORE);
  assign m1_gnt_o = accept && (sel == M_LOADER);

  assign pop         = s_rvalid_i && !fifo_empty;
  assign m0_rvalid_o = pop && (head_id == M_CORE);
  assign m1_rvalid_o = pop && (head_id == M_LOADER);
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant <= M_LOADER;
      resp_err_o <= 1'b0;
    end else begin
      if (accept) last_grant <= sel;
      if (s_rvalid_i && fifo_empty) resp_err_o <= 1'b1;
    end
  end

  sram_d_arb_idfifo #(
    .DEPTH(OUTSTANDING_DEPTH)
  ) u_idfifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (accept),
    .push_id_i(sel),
    .pop_i    (pop),
    .head_o   (head_id),
    .count_o  (unused_count),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Directed self-checking bench for sram_d_arbiter (round-robin and fixed-priority instances).
module tb_sram_d_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        s_gnt, s_rvalid;
  logic [31:0] s_rdata;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, s_req, s_we, resp_err;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_be;

  logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid, fp_s_req, fp_s_we, fp_resp_err;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic [3:0]  fp_s_be;

  int n_cmp = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  sram_d_arbiter #(.OUTSTANDING_DEPTH(2), .FIXED_PRIORITY(0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be),
    .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .resp_err_o(resp_err)
  );

  sram_d_arbiter #(.OUTSTANDING_DEPTH(2), .FIXED_PRIORITY(1)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_gnt_o(fp_m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(fp_m0_rvalid), .m0_rdata_o(fp_m0_rdata),
    .m1_req_i(m1_req), .m1_gnt_o(fp_m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(fp_m1_rvalid), .m1_rdata_o(fp_m1_rdata),
    .s_req_o(fp_s_req), .s_gnt_i(s_gnt), .s_addr_o(fp_s_addr), .s_we_o(fp_s_we), .s_be_o(fp_s_be),
    .s_wdata_o(fp_s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .resp_err_o(fp_resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_be = 4'h0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_be = 4'h0; m1_addr = '0; m1_wdata = '0;
    s_gnt = 0; s_rvalid = 0; s_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    logic [0:0] rr_order [4];
    logic [0:0] exp_id;
    rr_order[0] = 1'b0; rr_order[1] = 1'b1; rr_order[2] = 1'b0; rr_order[3] = 1'b1;

    // Reset state
    idle_inputs();
    rst_n = 0;
    #2;
    check("rst_s_req", {31'b0, s_req}, 0);
    check("rst_m0_gnt", {31'b0, m0_gnt}, 0);
    check("rst_m1_rvalid", {31'b0, m1_rvalid}, 0);
    check("rst_resp_err", {31'b0, resp_err}, 0);
    check("rst_s_addr", s_addr, 0);
    tick();
    rst_n = 1;
    tick();

    // Single master read
    m0_req = 1; m0_addr = 32'h8000_0010; m0_be = 4'hF; s_gnt = 1;
    #1;
    check("single_m0_gnt", {31'b0, m0_gnt}, 1);
    check("single_m1_gnt", {31'b0, m1_gnt}, 0);
    check("single_s_addr", s_addr, 32'h8000_0010);
    check("single_s_be", {28'b0, s_be}, 32'hF);
    tick();
    m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'h1234_5678;
    #1;
    check("single_m0_rvalid", {31'b0, m0_rvalid}, 1);
    check("single_m0_rdata", m0_rdata, 32'h1234_5678);
    check("single_m1_rvalid", {31'b0, m1_rvalid}, 0);
    check("single_m1_rdata", m1_rdata, 0);
    tick();

    // Round-robin contention with a 1-cycle responder
    do_reset();
    m0_addr = 32'h0000_0100; m0_we = 0; m0_be = 4'hF;
    m1_addr = 32'h0000_0200; m1_we = 1; m1_be = 4'h3; m1_wdata = 32'hDEAD_0001;
    for (int i = 0; i < 5; i++) begin
      m0_req = (i < 4); m1_req = (i < 4); s_gnt = 1;
      s_rvalid = (i > 0); s_rdata = 32'hA000_0000 + i;
      #1;
      if (i < 4) begin
        check($sformatf("rr_m0_gnt%0d", i), {31'b0, m0_gnt}, {31'b0, ~rr_order[i]});
        check($sformatf("rr_m1_gnt%0d", i), {31'b0, m1_gnt}, {31'b0, rr_order[i]});
        check($sformatf("rr_s_addr%0d", i), s_addr,
              rr_order[i] ? 32'h0000_0200 : 32'h0000_0100);
        check($sformatf("rr_s_we%0d", i), {31'b0, s_we}, {31'b0, rr_order[i]});
        exp_q.push_back(rr_order[i]);
      end
      if (i > 0) begin
        exp_id = exp_q.pop_front();
        check($sformatf("rr_m0_rv%0d", i), {31'b0, m0_rvalid}, {31'b0, ~exp_id});
        check($sformatf("rr_m1_rv%0d", i), {31'b0, m1_rvalid}, {31'b0, exp_id});
        check($sformatf("rr_rdata%0d", i), exp_id ? m1_rdata : m0_rdata, 32'hA000_0000 + i);
      end
      tick();
    end
    idle_inputs();

    // Fixed priority instance: m0 wins every tie
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m0_req = (i < 3); m1_req = (i < 3); s_gnt = 1; s_rvalid = (i > 0);
      #1;
      if (i < 3) begin
        check($sformatf("fp_m0_gnt%0d", i), {31'b0, fp_m0_gnt}, 1);
        check($sformatf("fp_m1_gnt%0d", i), {31'b0, fp_m1_gnt}, 0);
      end
      tick();
    end
    idle_inputs();

    // Back-pressure and full FIFO
    do_reset();
    m0_req = 1; m0_addr = 32'h0000_0040; s_gnt = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("bp_hold_gnt%0d", i), {31'b0, m0_gnt}, 0);
      check($sformatf("bp_hold_req%0d", i), {31'b0, s_req}, 1);
      tick();
    end
    s_gnt = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("bp_acc_gnt%0d", i), {31'b0, m0_gnt}, 1);
      tick();
    end
    #1;
    check("bp_full_s_req", {31'b0, s_req}, 0);
    check("bp_full_m0_gnt", {31'b0, m0_gnt}, 0);
    tick();
    s_rvalid = 1; s_rdata = 32'h0000_00AA;
    #1;
    check("bp_pop_rvalid", {31'b0, m0_rvalid}, 1);
    check("bp_pop_s_req", {31'b0, s_req}, 0);
    tick();
    s_rvalid = 0;
    #1;
    check("bp_resume_s_req", {31'b0, s_req}, 1);
    check("bp_resume_gnt", {31'b0, m0_gnt}, 1);
    tick();
    m0_req = 0; s_gnt = 0; s_rvalid = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("bp_drain_rv%0d", i), {31'b0, m0_rvalid}, 1);
      tick();
    end
    s_rvalid = 0;
    #1;
    check("bp_no_err", {31'b0, resp_err}, 0);
    tick();

    // Spurious response with empty FIFO
    s_rvalid = 1; s_rdata = 32'h5555_5555;
    #1;
    check("spur_m0_rvalid", {31'b0, m0_rvalid}, 0);
    check("spur_m1_rvalid", {31'b0, m1_rvalid}, 0);
    check("spur_m0_rdata", m0_rdata, 0);
    tick();
    s_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("spur_err_sticky%0d", i), {31'b0, resp_err}, 1);
      tick();
    end

    // Reset mid-flight: one m0 transaction outstanding, last grant m0
    m0_req = 1; s_gnt = 1;
    #1;
    check("mid_pre_gnt", {31'b0, m0_gnt}, 1);
    tick();
    m0_req = 0; s_gnt = 0;
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_err", {31'b0, resp_err}, 0);
    check("mid_rst_s_req", {31'b0, s_req}, 0);
    #2;
    rst_n = 1;
    tick();
    s_rvalid = 1; s_rdata = 32'h0BAD_0BAD;
    #1;
    check("mid_stale_m0_rv", {31'b0, m0_rvalid}, 0);
    tick();
    s_rvalid = 0;
    #1;
    check("mid_stale_err", {31'b0, resp_err}, 1);
    tick();
    m0_req = 1; m1_req = 1; s_gnt = 1;
    #1;
    check("mid_tie_m0_gnt", {31'b0, m0_gnt}, 1);
    check("mid_tie_m1_gnt", {31'b0, m1_gnt}, 0);
    tick();
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
